i2s_sample_capture: RTL and testbench

Downstream stage of the S/PDIF decoder. Oversamples the decoder's I2S outputs (`i2s_bck`, `i2s_ws`, `i2s_d0`) in the shared `clk` domain and assembles them into parallel left/right PCM words. Complete stereo pairs are presented on a valid/ready interface backed by a one-deep output register. The block also provides lock, short-word and overflow status.

---
 rtl/i2s_sample_capture.sv | 128 ++++++++++++
 tb/tb_i2s_sample_capture.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_sample_capture.sv
// I2S oversampling capture: rebuilds left/right PCM words from the decoder's
// bit stream and presents stereo pairs on a one-deep valid/ready register.
module i2s_sample_capture #(
    parameter int DATA_W     = 24,
    parameter int LOCK_PAIRS = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i2s_bck,
    input  logic              i2s_ws,
    input  logic              i2s_d0,
    output logic [DATA_W-1:0] out_left,
    output logic [DATA_W-1:0] out_right,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              locked,
    output logic              short_err,
    output logic              overflow
);

    localparam logic [1:0] ST_SEEK  = 2'd0;
    localparam logic [1:0] ST_LEFT  = 2'd1;
    localparam logic [1:0] ST_RIGHT = 2'd2;

    localparam logic [4:0] FULL     = 5'(DATA_W);
    localparam logic [4:0] CNT_MAX  = 5'd31;
    localparam logic [3:0] LOCK_MAX = 4'(LOCK_PAIRS);

    logic              bck_d;
    logic              ws_last;
    logic [4:0]        bitcnt;
    logic [DATA_W-1:0] sr;
    logic [DATA_W-1:0] left_hold;
    logic [1:0]        state;
    logic [3:0]        lock_cnt;

    logic rise;
    logic boundary;
    logic word_ok;
    logic short_hit;
    logic pair_done;
    logic accept;
    logic load;

    assign rise      = i2s_bck & ~bck_d;
    assign boundary  = rise & (i2s_ws != ws_last);
    assign word_ok   = (bitcnt >= FULL);
    assign short_hit = boundary & (state != ST_SEEK) & ~word_ok;
    assign pair_done = boundary & (state == ST_RIGHT) & word_ok;
    assign accept    = out_valid & out_ready;
    assign load      = pair_done & (~out_valid | out_ready);
    assign locked    = (lock_cnt == LOCK_MAX);

    // Bit assembly: the bit sampled at a boundary is the new word's MSB.
    always_ff @(posedge clk) begin
        if (rst) begin
            bck_d   <= 1'b0;
            ws_last <= 1'b0;
            bitcnt  <= 5'd0;
            sr      <= '0;
        end else begin
            bck_d <= i2s_bck;
            if (rise) begin
                ws_last <= i2s_ws;
                if (boundary) begin
                    sr     <= {{(DATA_W-1){1'b0}}, i2s_d0};
                    bitcnt <= 5'd1;
                end else begin
                    if (bitcnt < FULL)
                        sr <= {sr[DATA_W-2:0], i2s_d0};
                    if (bitcnt != CNT_MAX)
                        bitcnt <= bitcnt + 5'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_SEEK;
            left_hold <= '0;
        end else if (boundary) begin
            priority case (1'b1)
                (state == ST_SEEK): begin
                    if (!i2s_ws)
                        state <= ST_LEFT;
                end
                short_hit: begin
                    state <= ST_SEEK;
                end
                (state == ST_LEFT): begin
                    left_hold <= sr;
                    state     <= ST_RIGHT;
                end
                default: begin
                    state <= ST_LEFT;
                end
            endcase
        end
    end

    // Output register and status; an overflowed pair still counts toward lock.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_left  <= '0;
            out_right <= '0;
            out_valid <= 1'b0;
            short_err <= 1'b0;
            overflow  <= 1'b0;
            lock_cnt  <= 4'd0;
        end else begin
            short_err <= short_hit;
            overflow  <= pair_done & out_valid & ~out_ready;
            if (load) begin
                out_left  <= left_hold;
                out_right <= sr;
                out_valid <= 1'b1;
            end else if (accept) begin
                out_valid <= 1'b0;
            end
            if (short_hit)
                lock_cnt <= 4'd0;
            else if (pair_done && lock_cnt != LOCK_MAX)
                lock_cnt <= lock_cnt + 4'd1;
        end
    end

endmodule

// File: tb/tb_i2s_sample_capture.sv
// Bench for i2s_sample_capture: word-level stream model, directed frames
// followed by randomized word lengths, bit rates and consumer stalls.
module tb_i2s_sample_capture;

    localparam int DW = 24;
    localparam int LP = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          i2s_bck = 1'b0;
    logic          i2s_ws = 1'b0;
    logic          i2s_d0 = 1'b0;
    logic          out_ready = 1'b1;
    logic [DW-1:0] out_left;
    logic [DW-1:0] out_right;
    logic          out_valid;
    logic          locked;
    logic          short_err;
    logic          overflow;

    i2s_sample_capture #(.DATA_W(DW), .LOCK_PAIRS(LP)) dut (
        .clk       (clk),
        .rst       (rst),
        .i2s_bck   (i2s_bck),
        .i2s_ws    (i2s_ws),
        .i2s_d0    (i2s_d0),
        .out_left  (out_left),
        .out_right (out_right),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .locked    (locked),
        .short_err (short_err),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int half  = 4;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Word-level reference: pairs expected, shorts, lock depth
    logic [2*DW-1:0] q[$];
    logic            m_ws_last;
    int              m_prev_n;
    logic [DW-1:0]   m_prev_data;
    bit              m_aligned;
    bit              m_have_left;
    logic [DW-1:0]   m_left;
    int              m_lock;
    int              exp_short = 0;
    int              exp_ovf = 0;
    int              got_short = 0;
    int              got_ovf = 0;

    task automatic model_reset();
        m_ws_last   = 1'b0;
        m_prev_n    = 0;
        m_prev_data = '0;
        m_aligned   = 0;
        m_have_left = 0;
        m_left      = '0;
        m_lock      = 0;
        q.delete();
    endtask

    task automatic model_word(input logic ws, input int n,
                              input logic [DW-1:0] data);
        bit was;
        if (ws != m_ws_last) begin
            was = m_aligned;
            if (was) begin
                if (m_prev_n < DW) begin
                    exp_short++;
                    m_aligned   = 0;
                    m_have_left = 0;
                    m_lock      = 0;
                end else if (!m_have_left) begin
                    m_left      = m_prev_data;
                    m_have_left = 1;
                end else begin
                    q.push_back({m_left, m_prev_data});
                    m_have_left = 0;
                    if (m_lock < LP) m_lock++;
                end
            end
            if (!was && ws == 1'b0) begin
                m_aligned   = 1;
                m_have_left = 0;
            end
            m_prev_n    = n;
            m_prev_data = data;
        end else begin
            m_prev_n += n;
        end
        m_ws_last = ws;
    endtask

    function automatic logic bit_of(input logic [DW-1:0] data, input int i);
        if (i < DW) return data[DW-1-i];
        return 1'($urandom_range(0, 1));
    endfunction

    // Returns inside the rise cycle of the bit.
    task automatic lead_bit(input logic ws, input logic d);
        @(posedge clk); #1;
        i2s_bck = 1'b0;
        i2s_ws  = ws;
        i2s_d0  = d;
        repeat (half - 1) @(posedge clk);
        @(posedge clk); #1;
        i2s_bck = 1'b1;
    endtask

    task automatic word_head(input logic ws, input int n,
                             input logic [DW-1:0] data);
        model_word(ws, n, data);
        lead_bit(ws, bit_of(data, 0));
    endtask

    task automatic word_tail(input logic ws, input int n,
                             input logic [DW-1:0] data);
        repeat (half - 1) @(posedge clk);
        for (int i = 1; i < n; i++) begin
            lead_bit(ws, bit_of(data, i));
            repeat (half - 1) @(posedge clk);
        end
    endtask

    task automatic send_word(input logic ws, input int n,
                             input logic [DW-1:0] data);
        word_head(ws, n, data);
        word_tail(ws, n, data);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst     = 1'b1;
        i2s_bck = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic set_ready(input logic r);
        @(posedge clk); #1;
        out_ready = r;
    endtask

    task automatic check_zero(input string tag);
        @(negedge clk);
        check({tag, "_valid"}, out_valid, 0);
        check({tag, "_left"}, out_left, 0);
        check({tag, "_right"}, out_right, 0);
        check({tag, "_locked"}, locked, 0);
        check({tag, "_short"}, short_err, 0);
        check({tag, "_ovf"}, overflow, 0);
    endtask

    // Consumer-side monitor: accepted pairs, held-pair stability, pulses.
    logic          prev_valid = 1'b0;
    logic          prev_acc = 1'b0;
    logic [DW-1:0] prev_l = '0;
    logic [DW-1:0] prev_r = '0;

    always @(negedge clk) begin
        if (rst) begin
            prev_valid = 1'b0;
        end else begin
            if (short_err) got_short++;
            if (overflow) got_ovf++;
            if (out_valid && prev_valid && !prev_acc) begin
                check("hold_left", out_left, prev_l);
                check("hold_right", out_right, prev_r);
            end
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    check("spurious_pair", 1, 0);
                end else begin
                    check("pair_left", out_left, q[0][2*DW-1:DW]);
                    check("pair_right", out_right, q[0][DW-1:0]);
                    void'(q.pop_front());
                end
            end
            prev_valid = out_valid;
            prev_acc   = out_valid & out_ready;
            prev_l     = out_left;
            prev_r     = out_right;
        end
    end

    localparam logic [DW-1:0] PA = 24'hA5A5A5;
    localparam logic [DW-1:0] PB = 24'h5A5A5A;
    localparam logic [DW-1:0] PL = 24'h800001;
    localparam logic [DW-1:0] PR = 24'h000001;

    bit            rnd_on;
    logic          rws;
    int            rn;
    logic [DW-1:0] rd;

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check_zero("reset");

        // 32-bit frames at 8 clk/bit, entering mid-right-word
        half = 4;
        send_word(1, 32, PB);
        send_word(0, 32, PA);
        send_word(1, 32, PB);
        word_head(0, 32, PA);
        @(negedge clk);
        check("lat_pre", out_valid, 0);
        @(negedge clk);
        check("lat_post", out_valid, 1);
        word_tail(0, 32, PA);
        send_word(1, 32, PB);
        check("lock_1pair", locked, 0);
        send_word(0, 32, PA);
        check("lock_2pair", locked, (m_lock == LP));
        send_word(1, 32, PB);

        // Exact-width words, then a one-bit-short left word
        half = 2;
        send_word(0, 24, PL);
        send_word(1, 24, PR);
        send_word(0, 24, PL);
        send_word(1, 24, PR);
        send_word(0, 23, PL);
        send_word(1, 24, PR);
        @(negedge clk);
        check("short_cnt", got_short, exp_short);
        check("short_lock", locked, 0);
        check("short_seek", m_aligned, 0);
        send_word(0, 24, PR);
        send_word(1, 24, PL);
        send_word(0, 24, PA);
        check("resync_lock", locked, (m_lock == LP));
        check("resync_drain", q.size(), 0);

        // Two pairs completed while stalled
        set_ready(0);
        send_word(1, 24, 24'h111111);
        send_word(0, 24, 24'h222222);
        send_word(1, 24, 24'h333333);
        word_head(0, 24, 24'h444444);
        exp_ovf++;
        q.delete(1);
        word_tail(0, 24, 24'h444444);
        check("ovf_cnt", got_ovf, exp_ovf);
        check("ovf_held_l", out_left, q[0][2*DW-1:DW]);
        set_ready(1);
        repeat (3) @(negedge clk);
        check("ovf_drain", q.size(), 0);
        check("ovf_valid", out_valid, 0);

        // Accept in the very cycle a new pair completes
        set_ready(0);
        send_word(1, 24, 24'h555555);
        send_word(0, 24, 24'h666666);
        send_word(1, 24, 24'h777777);
        word_head(0, 24, 24'h888888);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        @(negedge clk);
        check("pulse_valid", out_valid, 1);
        check("pulse_left", out_left, q[0][2*DW-1:DW]);
        check("pulse_right", out_right, q[0][DW-1:0]);
        word_tail(0, 24, 24'h888888);
        check("pulse_ovf", got_ovf, exp_ovf);
        set_ready(1);
        repeat (3) @(negedge clk);
        check("pulse_drain", q.size(), 0);

        // Fresh start mid-right-word with a short right fragment
        do_reset();
        send_word(1, 10, 24'h123456);
        send_word(0, 24, 24'h9ABCDE);
        @(negedge clk);
        check("seek_valid", out_valid, 0);
        check("seek_short", got_short, exp_short);
        send_word(1, 24, 24'h0F0F0F);
        send_word(0, 24, 24'hF0F0F0);
        send_word(1, 24, 24'h3C3C3C);

        // Reset mid-left-word while a pair is held
        set_ready(0);
        word_head(0, 24, 24'hC3C3C3);
        repeat (half - 1) @(posedge clk);
        for (int i = 1; i < 6; i++) begin
            lead_bit(0, bit_of(24'hC3C3C3, i));
            repeat (half - 1) @(posedge clk);
        end
        @(negedge clk);
        check("pre_rst_valid", out_valid, 1);
        check("pre_rst_lock", locked, (m_lock == LP));
        do_reset();
        check_zero("midrst");
        set_ready(1);
        send_word(1, 24, 24'h010203);
        send_word(0, 24, 24'h040506);
        send_word(1, 24, 24'h070809);
        send_word(0, 24, 24'h0A0B0C);
        check("relock_1", locked, 0);
        send_word(1, 24, 24'h0D0E0F);
        send_word(0, 24, 24'h101112);
        check("relock_2", locked, 1);

        // Random word lengths, bit rates and consumer stalls
        rnd_on = 1;
        rws    = 1'b1;
        fork
            begin
                for (int w = 0; w < 48; w++) begin
                    half = $urandom_range(1, 3);
                    rn = ($urandom_range(0, 7) == 0) ? $urandom_range(8, 23)
                                                     : $urandom_range(24, 32);
                    rd = DW'($urandom);
                    send_word(rws, rn, rd);
                    rws = ~rws;
                end
                rnd_on = 0;
            end
            begin
                while (rnd_on) begin
                    @(posedge clk); #1;
                    if (rnd_on) out_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        set_ready(1);
        repeat (4) @(negedge clk);
        check("rnd_drain", q.size(), 0);
        check("rnd_short", got_short, exp_short);
        check("rnd_ovf", got_ovf, exp_ovf);
        check("rnd_lock", locked, (m_lock == LP));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
